// File: rtl/mem_1r1w_rd_ctrl.sv
// Read-side controller for a 1R1W memory with fixed read latency.
// Issues reads, tracks them through a latency pipe and returns responses in order via a FIFO.
module mem_1r1w_rd_ctrl #(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [AW-1:0]                   req_addr,
    output logic                            read_0,
    output logic [AW-1:0]                   addr_0,
    input  logic [DW-1:0]                   dout_0,
    input  logic                            read_serr_0,
    input  logic                            read_derr_0,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DW-1:0]                   rsp_data,
    output logic                            rsp_serr,
    output logic                            rsp_derr,
    output logic                            rsp_oor,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight,
    output logic                            err_sticky
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned EW = DW + 3;
    // One extra bit so WORDS == 2**AW is representable in the range compare.
    localparam logic [AW:0] WordsExt = (AW + 1)'(WORDS);

    if ((LATENCY == 0) || (LATENCY > 29)) begin : g_bad_latency
        $fatal(1, "ERR: LATENCY=%0d outside legal range 1..29", LATENCY);
    end
    if (FIFO_DEPTH == 0) begin : g_bad_depth
        $fatal(1, "ERR: FIFO_DEPTH must be >= 1");
    end

    logic [CW-1:0]      inflight_q, inflight_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] oor_q, oor_d;
    logic [EW-1:0]      fifo_q [FIFO_DEPTH];
    logic [EW-1:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_sticky_q, err_sticky_d;

    logic               req_oor;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [EW-1:0]      cap_entry;
    logic [EW-1:0]      head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request side: credit comes from the registered count only.
    always_comb begin
        req_oor   = ({1'b0, req_addr} >= WordsExt);
        req_ready = rst && (inflight_q < CW'(FIFO_DEPTH));
        accept    = req_valid && req_ready;
        read_0    = accept && !req_oor;
        addr_0    = req_addr;
    end

    // Latency tracking pipe; stage LATENCY-1 lines up with dout_0.
    always_comb begin
        vld_d    = '0;
        oor_d    = '0;
        vld_d[0] = accept;
        oor_d[0] = accept && req_oor;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            oor_d[i] = oor_q[i-1];
        end
    end

    // Entry layout: {data, serr, derr, oor}.
    always_comb begin
        push      = vld_q[LATENCY-1];
        cap_entry = oor_q[LATENCY-1] ? {{DW{1'b0}}, 3'b001}
                                     : {dout_0, read_serr_0, read_derr_0, 1'b0};
        head      = fifo_q[rd_ptr_q];
        rsp_valid = rst && (cnt_q != '0);
        pop       = rsp_valid && rsp_ready;
        fifo_full = (cnt_q == CW'(FIFO_DEPTH));
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = cap_entry;
        end
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        inflight_d   = inflight_q + CW'(accept) - CW'(pop);
        err_sticky_d = err_sticky_q || (pop && (head[2] || head[1] || head[0]));
    end

    always_comb begin
        rsp_data   = head[EW-1:3];
        rsp_serr   = head[2];
        rsp_derr   = head[1];
        rsp_oor    = head[0];
        inflight   = inflight_q;
        err_sticky = err_sticky_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q   <= '0;
            vld_q        <= '0;
            oor_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            vld_q        <= vld_d;
            oor_q        <= oor_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Storage needs no reset: entries are only visible below cnt_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    a_no_full_capture : assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_mem_1r1w_rd_ctrl.sv
// Bench for mem_1r1w_rd_ctrl: directed scenarios plus a random phase, checked every cycle
// against a transaction-level model (in-order queue with availability times).
module tb_mem_1r1w_rd_ctrl;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned WORDS = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          read_0;
    logic [AW-1:0] addr_0;
    logic [DW-1:0] dout_0;
    logic          read_serr_0;
    logic          read_derr_0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_serr;
    logic          rsp_derr;
    logic          rsp_oor;
    logic [CW-1:0] inflight;
    logic          err_sticky;

    mem_1r1w_rd_ctrl #(
        .AW         (AW),
        .DW         (DW),
        .WORDS      (WORDS),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .read_0      (read_0),
        .addr_0      (addr_0),
        .dout_0      (dout_0),
        .read_serr_0 (read_serr_0),
        .read_derr_0 (read_derr_0),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_serr    (rsp_serr),
        .rsp_derr    (rsp_derr),
        .rsp_oor     (rsp_oor),
        .inflight    (inflight),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents and per-address error flags, fixed read latency.
    logic [DW-1:0] mem    [WORDS];
    logic          serr_f [WORDS];
    logic          derr_f [WORDS];
    logic [LAT-1:0] mp_vld;
    logic [AW-1:0]  mp_addr [LAT];
    logic [DW-1:0]  noise_q;

    always @(posedge clk) begin
        mp_vld[0]  <= read_0;
        mp_addr[0] <= addr_0;
        for (int i = 1; i < int'(LAT); i++) begin
            mp_vld[i]  <= mp_vld[i-1];
            mp_addr[i] <= mp_addr[i-1];
        end
        noise_q <= $urandom;
    end

    // Outside a valid return slot the memory pins carry junk the DUT must ignore.
    always_comb begin
        dout_0      = noise_q;
        read_serr_0 = noise_q[0];
        read_derr_0 = noise_q[1];
        if (mp_vld[LAT-1] === 1'b1) begin
            dout_0      = mem[mp_addr[LAT-1][9:0]];
            read_serr_0 = serr_f[mp_addr[LAT-1][9:0]];
            read_derr_0 = derr_f[mp_addr[LAT-1][9:0]];
        end
    end

    typedef struct {
        int            avail;
        logic [DW-1:0] data;
        logic          serr;
        logic          derr;
        logic          oor;
    } exp_t;

    exp_t q[$];
    logic m_sticky;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic dropped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        exp_t h;
        logic accept_m;
        logic pop_m;
        logic vld_m;
        int   qs;
        @(negedge clk);
        qs       = q.size();
        vld_m    = rst && (qs != 0) && (q[0].avail <= cyc);
        accept_m = rst && req_valid && (qs < int'(DEPTH));
        pop_m    = vld_m && rsp_ready;
        chk("req_ready", 64'(req_ready), 64'(rst && (qs < int'(DEPTH))));
        chk("read_0", 64'(read_0), 64'(accept_m && (req_addr < AW'(WORDS))));
        if (accept_m && (req_addr < AW'(WORDS))) begin
            chk("addr_0", 64'(addr_0), 64'(req_addr));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(vld_m));
        if (vld_m) begin
            chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
            chk("rsp_serr", 64'(rsp_serr), 64'(q[0].serr));
            chk("rsp_derr", 64'(rsp_derr), 64'(q[0].derr));
            chk("rsp_oor", 64'(rsp_oor), 64'(q[0].oor));
        end
        chk("inflight", 64'(inflight), 64'(qs));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            if (pop_m) begin
                h = q.pop_front();
                if (h.serr || h.derr || h.oor) m_sticky = 1'b1;
            end
            if (accept_m) begin
                h.avail = cyc + int'(LAT) + 1;
                if (req_addr >= AW'(WORDS)) begin
                    h.data = '0;
                    h.serr = 1'b0;
                    h.derr = 1'b0;
                    h.oor  = 1'b1;
                end else begin
                    h.data = mem[req_addr[9:0]];
                    h.serr = serr_f[req_addr[9:0]];
                    h.derr = derr_f[req_addr[9:0]];
                    h.oor  = 1'b0;
                end
                q.push_back(h);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        m_sticky  = 1'b0;
        dropped   = 1'b0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]    = $urandom;
            serr_f[i] = 1'b0;
            derr_f[i] = 1'b0;
        end
        mem[5] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        step();
        rst = 1'b1;
        step();

        // Single read of address 5.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = AW'(5);
        step();
        idle(5);

        // 16 back-to-back reads, full throughput.
        for (int i = 0; i < 16; i++) begin
            if (req_ready !== 1'b1) dropped = 1'b1;
            req_valid = 1'b1;
            req_addr  = AW'(i);
            step();
        end
        chk("t2_ready_held", 64'(dropped), 64'(0));
        idle(6);

        // Backpressure: credits run out after DEPTH accepts.
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'($urandom_range(0, WORDS - 1));
            step();
        end
        chk("t3_inflight_full", 64'(inflight), 64'(DEPTH));
        chk("t3_ready_low", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        idle(8);
        chk("t3_inflight_drained", 64'(inflight), 64'(0));

        // Out-of-range address.
        req_valid = 1'b1;
        req_addr  = AW'(WORDS);
        step();
        idle(6);
        chk("t4_sticky", 64'(err_sticky), 64'(1));

        // Clear sticky, then a single-bit error on the middle read of three.
        rst = 1'b0;
        step();
        rst = 1'b1;
        serr_f[101] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(100 + i);
            step();
        end
        idle(6);
        chk("t5_sticky", 64'(err_sticky), 64'(1));

        // Reset with reads in flight; returning memory data must be dropped.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(200 + i);
            step();
        end
        req_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_inflight", 64'(inflight), 64'(0));
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        idle(6);

        // Random traffic including OOR addresses and error flags.
        for (int i = 0; i < int'(WORDS); i++) begin
            serr_f[i] = ($urandom_range(0, 15) == 0);
            derr_f[i] = ($urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom_range(0, 1100));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready = 1'b1;
        idle(10);
        chk("final_inflight", 64'(inflight), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
